pcs_receive: RTL

//  1000BASE-X PCS receive path (IEEE 802.3 cl.36 receive SM, reduced). Takes 10-bit code-groups

---
 rtl/pcs_receive.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive path: 10-bit code-groups in, GMII RXD/RX_DV/RX_ER out.
// Decodes 8b/10b, tracks running disparity and runs the reduced receive state machine.
module pcs_receive #(
  parameter bit CHECK_RD = 1'b1
) (
  input  logic       Clk,
  input  logic       mr_main_reset,
  input  logic [9:0] rx_code_group,
  input  logic       PUDI_indicate,
  input  logic       sync_status,
  output logic [7:0] RXD,
  output logic       RX_DV,
  output logic       RX_ER,
  output logic       rx_even
);

  typedef enum logic [2:0] {
    LINK_FAILED, WAIT_FOR_K, RX_K, IDLE_D,
    RECEIVE, TRI, TRR, RX_INVALID
  } state_t;

  state_t     state, state_nx;
  logic       rd, rd6, rd_nx;
  logic [7:0] rxd_nx;
  logic       dv_nx, er_nx, even_nx;

  logic [5:0] s6;
  logic [3:0] s4;
  logic [2:0] n6, n4, y;
  logic [4:0] x;
  logic [7:0] dec;
  logic       v6, v4, k28, a7_ok, derr, rd_ok;
  logic       d_ok, k_ok, s_ok, t_ok, r_ok, valid;

  assign s6 = rx_code_group[9:4];
  assign s4 = rx_code_group[3:0];
  assign n6 = 3'($countones(s6));
  assign n4 = 3'($countones(s4));

  always_comb begin
    v6  = 1'b1;
    k28 = 1'b0;
    x   = 5'd0;
    case (s6)
      6'b100111, 6'b011000: x = 5'd0;
      6'b011101, 6'b100010: x = 5'd1;
      6'b101101, 6'b010010: x = 5'd2;
      6'b110001:            x = 5'd3;
      6'b110101, 6'b001010: x = 5'd4;
      6'b101001:            x = 5'd5;
      6'b011001:            x = 5'd6;
      6'b111000, 6'b000111: x = 5'd7;
      6'b111001, 6'b000110: x = 5'd8;
      6'b100101:            x = 5'd9;
      6'b010101:            x = 5'd10;
      6'b110100:            x = 5'd11;
      6'b001101:            x = 5'd12;
      6'b101100:            x = 5'd13;
      6'b011100:            x = 5'd14;
      6'b010111, 6'b101000: x = 5'd15;
      6'b011011, 6'b100100: x = 5'd16;
      6'b100011:            x = 5'd17;
      6'b010011:            x = 5'd18;
      6'b110010:            x = 5'd19;
      6'b001011:            x = 5'd20;
      6'b101010:            x = 5'd21;
      6'b011010:            x = 5'd22;
      6'b111010, 6'b000101: x = 5'd23;
      6'b110011, 6'b001100: x = 5'd24;
      6'b100110:            x = 5'd25;
      6'b010110:            x = 5'd26;
      6'b110110, 6'b001001: x = 5'd27;
      6'b001110:            x = 5'd28;
      6'b101110, 6'b010001: x = 5'd29;
      6'b011110, 6'b100001: x = 5'd30;
      6'b101011, 6'b010100: x = 5'd31;
      6'b001111, 6'b110000: begin
        x   = 5'd28;
        k28 = 1'b1;
      end
      default: v6 = 1'b0;
    endcase
  end

  always_comb begin
    v4 = 1'b1;
    y  = 3'd0;
    case (s4)
      4'b1011, 4'b0100: y = 3'd0;
      4'b1001:          y = 3'd1;
      4'b0101:          y = 3'd2;
      4'b1100, 4'b0011: y = 3'd3;
      4'b1101, 4'b0010: y = 3'd4;
      4'b1010:          y = 3'd5;
      4'b0110:          y = 3'd6;
      4'b1110, 4'b0001,
      4'b0111, 4'b1000: y = 3'd7;
      default:          v4 = 1'b0;
    endcase
  end

  // Alternate D.x.7 is legal only after the sub-blocks that would
  // otherwise form a run of five.
  always_comb begin
    a7_ok = 1'b1;
    case (s4)
      4'b0111: a7_ok = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
      4'b1110: a7_ok = !((x == 5'd17) || (x == 5'd18) || (x == 5'd20));
      4'b1000: a7_ok = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
      4'b0001: a7_ok = !((x == 5'd11) || (x == 5'd13) || (x == 5'd14));
      default: a7_ok = 1'b1;
    endcase
  end

  always_comb begin
    rd6 = rd;
    if (n6 > 3'd3 || s6 == 6'b000111) rd6 = 1'b1;
    else if (n6 < 3'd3 || s6 == 6'b111000) rd6 = 1'b0;
    rd_nx = rd6;
    if (n4 > 3'd2 || s4 == 4'b0011) rd_nx = 1'b1;
    else if (n4 < 3'd2 || s4 == 4'b1100) rd_nx = 1'b0;
  end

  assign derr = (rd  ? (n6 > 3'd3 || s6 == 6'b111000)
                     : (n6 < 3'd3 || s6 == 6'b000111))
              | (rd6 ? (n4 > 3'd2 || s4 == 4'b1100)
                     : (n4 < 3'd2 || s4 == 4'b0011));
  assign rd_ok = !CHECK_RD || !derr;

  assign dec  = {y, x};
  assign d_ok = v6 && v4 && !k28 && a7_ok && rd_ok;
  assign k_ok = rd_ok && (rx_code_group == 10'b0011111010
                       || rx_code_group == 10'b1100000101);
  assign s_ok = rd_ok && (rx_code_group == 10'b1101101000
                       || rx_code_group == 10'b0010010111);
  assign t_ok = rd_ok && (rx_code_group == 10'b1011101000
                       || rx_code_group == 10'b0100010111);
  assign r_ok = rd_ok && (rx_code_group == 10'b1110101000
                       || rx_code_group == 10'b0001010111);
  assign valid = d_ok || k_ok || s_ok || t_ok || r_ok;

  always_comb begin
    state_nx = state;
    rxd_nx   = 8'h00;
    dv_nx    = 1'b0;
    er_nx    = 1'b0;
    even_nx  = ~rx_even;
    if (!sync_status) begin
      state_nx = LINK_FAILED;
      er_nx    = RX_DV;
    end else begin
      unique case (state)
        LINK_FAILED: state_nx = WAIT_FOR_K;
        WAIT_FOR_K, RX_INVALID: begin
          if (k_ok) begin
            state_nx = RX_K;
            even_nx  = 1'b1;
          end
        end
        RX_K: begin
          if (d_ok && (dec == 8'h50 || dec == 8'hC5)) state_nx = IDLE_D;
          else state_nx = RX_INVALID;
        end
        IDLE_D: begin
          if (k_ok) begin
            state_nx = RX_K;
          end else if (s_ok) begin
            state_nx = RECEIVE;
            rxd_nx   = 8'h55;
            dv_nx    = 1'b1;
          end else begin
            state_nx = RX_INVALID;
            if (valid) begin
              rxd_nx = 8'h0E;
              er_nx  = 1'b1;
            end
          end
        end
        RECEIVE: begin
          if (d_ok) begin
            rxd_nx = dec;
            dv_nx  = 1'b1;
          end else if (t_ok) begin
            state_nx = TRI;
          end else begin
            if (k_ok) state_nx = RX_K;
            dv_nx = 1'b1;
            er_nx = 1'b1;
          end
        end
        TRI: begin
          if (r_ok) state_nx = TRR;
          else state_nx = RX_INVALID;
        end
        TRR: begin
          if (k_ok) state_nx = RX_K;
          else if (!r_ok) state_nx = RX_INVALID;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!mr_main_reset) begin
      state   <= LINK_FAILED;
      rd      <= 1'b0;
      RXD     <= 8'h00;
      RX_DV   <= 1'b0;
      RX_ER   <= 1'b0;
      rx_even <= 1'b0;
    end else if (PUDI_indicate) begin
      state   <= state_nx;
      rd      <= rd_nx;
      RXD     <= rxd_nx;
      RX_DV   <= dv_nx;
      RX_ER   <= er_nx;
      rx_even <= even_nx;
    end
  end

endmodule
